rambus_stream_reader: RTL and testbench

//  Wishbone master on the shared OpenRAM "rambus" (port B of the OpenRAM wrapper); consumes RAM contents.

---
 rtl/rambus_stream_reader_pkg.sv | 16 +
 rtl/rambus_stream_reader_fifo.sv | 53 +++++
 rtl/rambus_stream_reader.sv | 169 ++++++++++++++++
 tb/tb_rambus_stream_reader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rambus_stream_reader_pkg.sv
// Shared definitions for the rambus stream reader: FSM encoding and bus constants.
package rambus_stream_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [3:0] SEL_ALL           = 4'hF;
  localparam int         WORD_BYTES        = 4;
  localparam int         RAMBUS_ADDR_WIDTH = 10;

endpackage

// File: rtl/rambus_stream_reader_fifo.sv
// Synchronous prefetch FIFO with occupancy count and single-cycle flush.
module rambus_stream_reader_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     rst_b,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/rambus_stream_reader.sv
// Read-only Wishbone master that cycles a word range of the rambus SRAM into a sample stream.
//  state    | meaning
//  ST_IDLE  | bus idle, waiting for enable
//  ST_REQ   | issuing reads; cyc low for one gap cycle after each ack
//  ST_HOLD  | FIFO full, bus idle until a pop frees an entry
//  ST_DRAIN | flush FIFO, return to idle
//  ST_ERR   | ack timeout seen, bus idle until enable drops
module rambus_stream_reader
  import rambus_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH     = RAMBUS_ADDR_WIDTH,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  cfg_enable_i,
  input  logic [ADDR_WIDTH-1:0] cfg_start_addr_i,
  input  logic [ADDR_WIDTH-1:0] cfg_end_addr_i,
  output logic                  rambus_wb_clk_o,
  output logic                  rambus_wb_rst_o,
  output logic                  rambus_wb_cyc_o,
  output logic                  rambus_wb_stb_o,
  output logic                  rambus_wb_we_o,
  output logic [3:0]            rambus_wb_sel_o,
  output logic [ADDR_WIDTH-1:0] rambus_wb_adr_o,
  output logic [31:0]           rambus_wb_dat_o,
  input  logic                  rambus_wb_ack_i,
  input  logic [31:0]           rambus_wb_dat_i,
  output logic [31:0]           sample_data_o,
  output logic                  sample_valid_o,
  input  logic                  sample_ready_i,
  output logic                  wrap_o,
  output logic                  busy_o,
  output logic                  timeout_err_o
);

  localparam int WAW = ADDR_WIDTH - 2;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES);

  state_t          state;
  logic [WAW-1:0]  addr;
  logic [WAW-1:0]  start_w;
  logic [WAW-1:0]  end_w;
  logic [WAW-1:0]  cfg_start_w;
  logic [WAW-1:0]  cfg_end_w;
  logic [7:0]      wait_cnt;
  logic            cyc;
  logic            discard;
  logic            wrap_q;
  logic            timeout_err_q;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   fill_after;
  logic            fifo_empty;
  logic            fifo_flush;
  logic            pop_fire;
  logic            ack_fire;
  logic            push;
  logic            unused_cfg_lsbs;

  assign cfg_start_w     = cfg_start_addr_i[ADDR_WIDTH-1:2];
  assign cfg_end_w       = cfg_end_addr_i[ADDR_WIDTH-1:2];
  assign unused_cfg_lsbs = ^{cfg_start_addr_i[1:0], cfg_end_addr_i[1:0]};

  assign ack_fire       = cyc && rambus_wb_ack_i;
  // Data of a read whose enable dropped while it was in flight is thrown away
  assign push           = ack_fire && cfg_enable_i && !discard;
  assign fifo_flush     = (state == ST_DRAIN);
  assign sample_valid_o = !fifo_empty && (state != ST_DRAIN);
  assign pop_fire       = sample_valid_o && sample_ready_i;
  assign fill_after     = fifo_count + CW'(1) - CW'(pop_fire);

  rambus_stream_reader_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys   (wb_clk_i),
    .rst_b     (wb_rst_n_i),
    .push      (push),
    .push_data (rambus_wb_dat_i),
    .pop       (pop_fire),
    .flush     (fifo_flush),
    .pop_data  (sample_data_o),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state         <= ST_IDLE;
      addr          <= '0;
      start_w       <= '0;
      end_w         <= '0;
      wait_cnt      <= '0;
      cyc           <= 1'b0;
      discard       <= 1'b0;
      wrap_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_enable_i) begin
            start_w       <= cfg_start_w;
            end_w         <= (cfg_end_w < cfg_start_w) ? cfg_start_w : cfg_end_w;
            addr          <= cfg_start_w;
            timeout_err_q <= 1'b0;
            discard       <= 1'b0;
            cyc           <= 1'b1;
            wait_cnt      <= TMO_LOAD;
            state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (cyc) begin
            if (!cfg_enable_i) discard <= 1'b1;
            if (ack_fire) begin
              cyc <= 1'b0;
              if (push) begin
                addr   <= (addr == end_w) ? start_w : addr + WAW'(1);
                wrap_q <= (addr == end_w);
                if (fill_after == CW'(FIFO_DEPTH)) state <= ST_HOLD;
              end else begin
                state <= ST_DRAIN;
              end
            end else if (wait_cnt == 8'd0) begin
              cyc           <= 1'b0;
              timeout_err_q <= 1'b1;
              state         <= ST_ERR;
            end else begin
              wait_cnt <= wait_cnt - 8'd1;
            end
          end else if (!cfg_enable_i) begin
            state <= ST_DRAIN;
          end else begin
            cyc      <= 1'b1;
            wait_cnt <= TMO_LOAD;
          end
        end
        ST_HOLD: begin
          if (!cfg_enable_i) begin
            state <= ST_DRAIN;
          end else if (pop_fire || fifo_count != CW'(FIFO_DEPTH)) begin
            cyc      <= 1'b1;
            wait_cnt <= TMO_LOAD;
            state    <= ST_REQ;
          end
        end
        ST_DRAIN: state <= ST_IDLE;
        ST_ERR:   if (!cfg_enable_i) state <= ST_DRAIN;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign rambus_wb_clk_o = wb_clk_i;
  assign rambus_wb_rst_o = ~wb_rst_n_i;
  assign rambus_wb_cyc_o = cyc;
  assign rambus_wb_stb_o = cyc;
  assign rambus_wb_we_o  = 1'b0;
  assign rambus_wb_sel_o = SEL_ALL;
  assign rambus_wb_adr_o = {addr, 2'b00};
  assign rambus_wb_dat_o = 32'h0;
  assign wrap_o          = wrap_q;
  assign busy_o          = (state != ST_IDLE);
  assign timeout_err_o   = timeout_err_q;

endmodule

// File: tb/tb_rambus_stream_reader.sv
// Directed self-checking bench for rambus_stream_reader with a behavioural rambus slave.
module tb_rambus_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [9:0]  start_addr;
  logic [9:0]  end_addr;
  logic        bus_clk, bus_rst, cyc, stb, we;
  logic [3:0]  sel;
  logic [9:0]  adr;
  logic [31:0] dat_o;
  logic        ack;
  logic [31:0] dat_i;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic        wrap, busy, terr;

  logic        slave_on;
  int          ack_delay;
  int          slave_cnt;
  logic [31:0] ram [256];

  int          rx_n = 0;
  logic [31:0] rx_mem [1024];
  int          ack_n = 0;
  int          wrap_n = 0;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] WA = 32'hAAAA_0001;
  localparam logic [31:0] WB = 32'hBBBB_0002;
  localparam logic [31:0] WC = 32'hCCCC_0003;
  localparam logic [31:0] WD = 32'hDDDD_0004;
  localparam logic [31:0] WE = 32'hEEEE_00FF;

  always #5 clk = ~clk;

  rambus_stream_reader dut (
    .wb_clk_i         (clk),
    .wb_rst_n_i       (rst_n),
    .cfg_enable_i     (enable),
    .cfg_start_addr_i (start_addr),
    .cfg_end_addr_i   (end_addr),
    .rambus_wb_clk_o  (bus_clk),
    .rambus_wb_rst_o  (bus_rst),
    .rambus_wb_cyc_o  (cyc),
    .rambus_wb_stb_o  (stb),
    .rambus_wb_we_o   (we),
    .rambus_wb_sel_o  (sel),
    .rambus_wb_adr_o  (adr),
    .rambus_wb_dat_o  (dat_o),
    .rambus_wb_ack_i  (ack),
    .rambus_wb_dat_i  (dat_i),
    .sample_data_o    (data),
    .sample_valid_o   (valid),
    .sample_ready_i   (ready),
    .wrap_o           (wrap),
    .busy_o           (busy),
    .timeout_err_o    (terr)
  );

  // Slave: acks ack_delay cycles after stb is first seen
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack       <= 1'b0;
      dat_i     <= 32'h0;
      slave_cnt <= 0;
    end else begin
      ack <= 1'b0;
      if (cyc && stb && !ack && slave_on) begin
        if (slave_cnt + 1 >= ack_delay) begin
          ack       <= 1'b1;
          dat_i     <= ram[adr[9:2]];
          slave_cnt <= 0;
        end else begin
          slave_cnt <= slave_cnt + 1;
        end
      end else begin
        slave_cnt <= 0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (valid && ready && rx_n < 1024) begin
        rx_mem[rx_n] <= data;
        rx_n         <= rx_n + 1;
      end
      if (ack && cyc) ack_n <= ack_n + 1;
      if (wrap) wrap_n <= wrap_n + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; ready = 1'b0;
    start_addr = '0; end_addr = '0;
    slave_on = 1'b1; ack_delay = 1;
    repeat (3) @(negedge clk);
    n_checks++; if (cyc !== 1'b0)  begin n_fail++; $display("FAIL rst_cyc got %b want 0", cyc); end
    n_checks++; if (stb !== 1'b0)  begin n_fail++; $display("FAIL rst_stb got %b want 0", stb); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_checks++; if (wrap !== 1'b0 || terr !== 1'b0) begin n_fail++; $display("FAIL rst_flags wrap=%b terr=%b want 0 0", wrap, terr); end
    n_checks++; if (bus_rst !== 1'b1) begin n_fail++; $display("FAIL rst_bus_rst got %b want 1", bus_rst); end
    n_checks++; if (sel !== 4'hF || we !== 1'b0 || dat_o !== 32'h0) begin n_fail++; $display("FAIL rst_consts sel=%h we=%b dat=%h want F 0 0", sel, we, dat_o); end
    n_checks++; if (data !== 32'h0 || adr !== 10'h0) begin n_fail++; $display("FAIL rst_data data=%h adr=%h want 0 0", data, adr); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus_rst !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_release bus_rst=%b busy=%b want 0 0", bus_rst, busy); end
  endtask

  task automatic test_stream();
    int r0, w0;
    bit ok;
    r0 = rx_n; w0 = wrap_n;
    start_addr = 10'h000; end_addr = 10'h00C; ready = 1'b1; ack_delay = 1;
    enable = 1'b1;
    @(negedge clk);
    n_checks++; if (cyc !== 1'b1 || adr !== 10'h000 || valid !== 1'b0) begin n_fail++; $display("FAIL t1_first_req cyc=%b adr=%h valid=%b want 1 000 0", cyc, adr, valid); end
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL t1_latency_early valid=%b want 0", valid); end
    @(negedge clk);
    n_checks++; if (valid !== 1'b1 || data !== WA) begin n_fail++; $display("FAIL t1_latency valid=%b data=%h want 1 %h", valid, data, WA); end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rx_n - r0 >= 10) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t1_collect got %0d samples want 10", rx_n - r0); end
    enable = 1'b0;
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t1_idle busy=%b want 0", busy); end
    repeat (2) @(negedge clk);
    n_checks++; if (rx_n - r0 !== 10) begin n_fail++; $display("FAIL t1_count got %0d want 10", rx_n - r0); end
    for (int i = 0; i < 10; i++) begin
      logic [31:0] exp;
      case (i % 4)
        0: exp = WA;
        1: exp = WB;
        2: exp = WC;
        default: exp = WD;
      endcase
      n_checks++; if (rx_mem[r0+i] !== exp) begin n_fail++; $display("FAIL t1_data[%0d] got %h want %h", i, rx_mem[r0+i], exp); end
    end
    n_checks++; if (wrap_n - w0 !== 2) begin n_fail++; $display("FAIL t1_wraps got %0d want 2", wrap_n - w0); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_after got %b want 0", valid); end
  endtask

  task automatic test_backpressure();
    int a0, r0;
    bit ok;
    a0 = ack_n; r0 = rx_n;
    start_addr = 10'h000; end_addr = 10'h00C; ready = 1'b0; ack_delay = 1;
    enable = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++; if (ack_n - a0 !== 4) begin n_fail++; $display("FAIL t2_acks_full got %0d want 4", ack_n - a0); end
    n_checks++; if (cyc !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL t2_hold cyc=%b busy=%b want 0 1", cyc, busy); end
    n_checks++; if (valid !== 1'b1 || data !== WA) begin n_fail++; $display("FAIL t2_head valid=%b data=%h want 1 %h", valid, data, WA); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (ack_n - a0 !== 5) begin n_fail++; $display("FAIL t2_one_read got %0d acks want 5", ack_n - a0); end
    n_checks++; if (rx_n - r0 !== 1 || rx_mem[r0] !== WA) begin n_fail++; $display("FAIL t2_pop n=%0d d=%h want 1 %h", rx_n - r0, rx_mem[r0], WA); end
    n_checks++; if (data !== WB || cyc !== 1'b0) begin n_fail++; $display("FAIL t2_next_head data=%h cyc=%b want %h 0", data, cyc, WB); end
    enable = 1'b0;
    wait_idle(ok);
    n_checks++; if (!ok || valid !== 1'b0) begin n_fail++; $display("FAIL t2_drain busy=%b valid=%b want 0 0", busy, valid); end
  endtask

  task automatic test_timeout();
    int hi;
    bit ok;
    slave_on = 1'b0; ready = 1'b1;
    start_addr = 10'h020; end_addr = 10'h020;
    enable = 1'b1;
    hi = 0;
    @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      if (!cyc) break;
      hi++;
      @(negedge clk);
    end
    n_checks++; if (hi !== 256) begin n_fail++; $display("FAIL t3_wait_cycles got %0d want 256", hi); end
    n_checks++; if (terr !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL t3_err terr=%b busy=%b want 1 1", terr, busy); end
    repeat (5) @(negedge clk);
    n_checks++; if (cyc !== 1'b0) begin n_fail++; $display("FAIL t3_bus_idle cyc=%b want 0", cyc); end
    enable = 1'b0;
    wait_idle(ok);
    n_checks++; if (!ok || terr !== 1'b1) begin n_fail++; $display("FAIL t3_sticky busy=%b terr=%b want 0 1", busy, terr); end
    slave_on = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    n_checks++; if (terr !== 1'b0) begin n_fail++; $display("FAIL t3_clear terr=%b want 0", terr); end
    enable = 1'b0;
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t3_idle busy=%b want 0", busy); end
  endtask

  task automatic test_abort();
    int a0, r0;
    bit ok;
    a0 = ack_n; r0 = rx_n;
    start_addr = 10'h000; end_addr = 10'h00C; ready = 1'b0; ack_delay = 2;
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack_n - a0 == 2 && cyc) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t4_third_req acks=%0d cyc=%b want 2 1", ack_n - a0, cyc); end
    enable = 1'b0;
    @(negedge clk);
    n_checks++; if (cyc !== 1'b1 || valid !== 1'b1 || data !== WA) begin n_fail++; $display("FAIL t4_inflight cyc=%b valid=%b data=%h want 1 1 %h", cyc, valid, data, WA); end
    wait_idle(ok);
    n_checks++; if (!ok || valid !== 1'b0) begin n_fail++; $display("FAIL t4_drain busy=%b valid=%b want 0 0", busy, valid); end
    n_checks++; if (ack_n - a0 !== 3 || rx_n - r0 !== 0) begin n_fail++; $display("FAIL t4_discard acks=%0d rx=%0d want 3 0", ack_n - a0, rx_n - r0); end
    ack_delay = 1; ready = 1'b1; r0 = rx_n;
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rx_n - r0 >= 1) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok || rx_mem[r0] !== WA) begin n_fail++; $display("FAIL t4_restart got %h want %h", rx_mem[r0], WA); end
    enable = 1'b0;
    wait_idle(ok);
  endtask

  task automatic test_single_word();
    int r0, w0, a0, bad;
    bit ok;
    r0 = rx_n; w0 = wrap_n; a0 = ack_n; bad = 0;
    start_addr = 10'h3FC; end_addr = 10'h010; ready = 1'b1; ack_delay = 1;
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cyc && adr !== 10'h3FC) bad++;
      if (rx_n - r0 >= 5) break;
    end
    n_checks++; if (rx_n - r0 < 5) begin n_fail++; $display("FAIL t5_collect got %0d want 5", rx_n - r0); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL t5_addr got %0d off-word reads want 0", bad); end
    enable = 1'b0;
    wait_idle(ok);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rx_mem[r0+i] !== WE) begin n_fail++; $display("FAIL t5_data[%0d] got %h want %h", i, rx_mem[r0+i], WE); end
    end
    n_checks++; if (wrap_n - w0 !== rx_n - r0) begin n_fail++; $display("FAIL t5_wraps got %0d want %0d", wrap_n - w0, rx_n - r0); end
  endtask

  task automatic test_reset_mid();
    int a0, r0;
    bit ok;
    a0 = ack_n;
    start_addr = 10'h000; end_addr = 10'h00C; ready = 1'b0; ack_delay = 1;
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack_n - a0 == 2 && cyc) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok || valid !== 1'b1) begin n_fail++; $display("FAIL t6_setup acks=%0d valid=%b want 2 1", ack_n - a0, valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin n_fail++; $display("FAIL t6_async_bus cyc=%b stb=%b want 0 0", cyc, stb); end
    n_checks++; if (valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL t6_async_state valid=%b busy=%b want 0 0", valid, busy); end
    repeat (2) @(negedge clk);
    ready = 1'b1; r0 = rx_n;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_n - r0 >= 2) break;
    end
    n_checks++; if (rx_n - r0 < 2 || rx_mem[r0] !== WA || rx_mem[r0+1] !== WB) begin n_fail++; $display("FAIL t6_restart n=%0d d0=%h d1=%h want %h %h", rx_n - r0, rx_mem[r0], rx_mem[r0+1], WA, WB); end
    enable = 1'b0;
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t6_idle busy=%b want 0", busy); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h5000_0000 | 32'(i);
    ram[0] = WA; ram[1] = WB; ram[2] = WC; ram[3] = WD; ram[255] = WE;
    test_reset();
    test_stream();
    test_backpressure();
    test_timeout();
    test_abort();
    test_single_word();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
